divider_top: RTL and testbench

- Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU.
- Sibling of the multiplier, driven by the same instruction decoder: div_on_o → div_en_i, signed_A_o → signed_i, upper_rem_o → rem_i.
- Takes two operands under a level enable/done handshake.
- Delivers the quotient or remainder after a fixed latency, with RISC-V special cases handled on a fast path.

---
 rtl/divider_top.sv | 101 ++++++++++
 tb/tb_divider_top.sv | 133 +++++++++++++
 2 files changed

// File: rtl/divider_top.sv
// divider_top: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module divider_top #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_en_i,
  input  logic [WIDTH-1:0] op_A_i,
  input  logic [WIDTH-1:0] op_B_i,
  input  logic             signed_i,
  input  logic             rem_i,
  output logic [WIDTH-1:0] result_o,
  output logic             done_o
);
  typedef enum logic [2:0] {IDLE, INIT, CALC, FIX, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, rem_q, quo_q;
  logic             sgn_q, sel_q;
  logic             a_neg, b_neg, div_zero, ovf;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;
  logic [WIDTH:0]   shifted, trial;
  // operand magnitudes, special-case detection, one restoring step and sign fix-up
  always_comb begin
    a_neg    = sgn_q & a_q[WIDTH-1];
    b_neg    = sgn_q & b_q[WIDTH-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    div_zero = b_q == '0;
    ovf      = sgn_q && a_q == MIN_NEG && b_q == '1;
    shifted  = {rem_q, quo_q[WIDTH-1]};
    trial    = shifted - {1'b0, b_mag};
    q_fix    = (a_neg ^ b_neg) ? -quo_q : quo_q;
    r_fix    = a_neg ? -rem_q : rem_q;
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else        state <= state_n;
  // next-state selection; CALC ends after the iteration where the counter is all ones
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = div_en_i ? INIT : IDLE;
      INIT:    state_n = (div_zero || ovf) ? DONE : CALC;
      CALC:    state_n = &cnt ? FIX : CALC;
      FIX:     state_n = DONE;
      DONE:    state_n = div_en_i ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // datapath: operand latch, fast-path results, iteration registers and result/done
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      sgn_q    <= 1'b0;
      sel_q    <= 1'b0;
      result_o <= '0;
      done_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (div_en_i) begin
          a_q    <= op_A_i;
          b_q    <= op_B_i;
          sgn_q  <= signed_i;
          sel_q  <= rem_i;
          done_o <= 1'b0;
        end
        INIT: begin
          cnt   <= '0;
          rem_q <= '0;
          quo_q <= a_mag;
          if (div_zero) begin
            result_o <= sel_q ? a_q : '1;
            done_o   <= 1'b1;
          end else if (ovf) begin
            result_o <= sel_q ? '0 : MIN_NEG;
            done_o   <= 1'b1;
          end
        end
        CALC: begin
          cnt   <= cnt + 1'b1;
          quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          rem_q <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        end
        FIX: begin
          result_o <= sel_q ? r_fix : q_fix;
          done_o   <= 1'b1;
        end
        DONE: if (!div_en_i) done_o <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_top.sv
// tb_divider_top: scoreboard bench for divider_top with directed RV32M vectors
module tb_divider_top;
  logic        clk = 1'b0, rst = 1'b0, div_en = 1'b0, sgn = 1'b0, rem = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, result;
  logic        done;
  int          compared = 0, mismatched = 0, cyc = 0;
  logic        done_prev = 1'b0;
  typedef struct {logic [31:0] res; int lat; int start;} exp_t;
  exp_t sb[$];
  typedef struct {logic [31:0] a; logic [31:0] b; logic s; logic r; logic [31:0] e; int lat;} vec_t;
  vec_t vecs[17];

  divider_top dut (
    .clk_i(clk), .rst_i(rst), .div_en_i(div_en), .op_A_i(op_a), .op_B_i(op_b),
    .signed_i(sgn), .rem_i(rem), .result_o(result), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // monitor: on each rising done, pop the oldest expectation and compare value and latency
  always @(negedge clk) begin
    if (done && !done_prev) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_done: got result=%h with empty scoreboard", result);
      end else begin
        exp_t x;
        x = sb.pop_front();
        if (result !== x.res || cyc - x.start != x.lat) begin
          mismatched++;
          $display("FAIL result: got %h at edge %0d, expected %h at edge %0d",
                   result, cyc - x.start, x.res, x.lat);
        end
      end
    end
    done_prev = done;
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: done_o=%b, expected 1 within 100 cycles", done);
    end
  endtask

  task automatic run(input vec_t v, input int hold, input bit scramble);
    @(negedge clk);
    op_a = v.a; op_b = v.b; sgn = v.s; rem = v.r; div_en = 1'b1;
    sb.push_back('{v.e, v.lat, cyc + 1});
    if (scramble) begin
      repeat (10) @(negedge clk);
      op_a = ~v.a; op_b = v.b + 32'd3; sgn = ~v.s; rem = ~v.r;
    end
    wait_done();
    repeat (hold) begin
      @(negedge clk);
      compared++;
      if (done !== 1'b1 || result !== v.e) begin
        mismatched++;
        $display("FAIL hold: done=%b result=%h, expected done=1 result=%h", done, result, v.e);
      end
    end
    div_en = 1'b0;
    @(negedge clk);
    compared++;
    if (done !== 1'b0) begin
      mismatched++;
      $display("FAIL drop: done=%b, expected 0", done);
    end
  endtask

  initial begin
    vecs[0]  = '{32'd100,       32'd7,         1'b0, 1'b0, 32'h0000000E, 34};
    vecs[1]  = '{32'd100,       32'd7,         1'b0, 1'b1, 32'h00000002, 34};
    vecs[2]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 1'b0, 32'hFFFFFFFD, 34};
    vecs[3]  = '{32'hFFFFFFF9,  32'd2,         1'b1, 1'b1, 32'hFFFFFFFF, 34};
    vecs[4]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  1'b1, 1'b1, 32'hFFFFFFFF, 34};
    vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 1'b0, 32'h80000000, 1};
    vecs[6]  = '{32'h80000000,  32'hFFFFFFFF,  1'b1, 1'b1, 32'h00000000, 1};
    vecs[7]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 1'b0, 32'h00000000, 34};
    vecs[8]  = '{32'h80000000,  32'hFFFFFFFF,  1'b0, 1'b1, 32'h80000000, 34};
    vecs[9]  = '{32'h12345678,  32'd0,         1'b0, 1'b0, 32'hFFFFFFFF, 1};
    vecs[10] = '{32'h12345678,  32'd0,         1'b0, 1'b1, 32'h12345678, 1};
    vecs[11] = '{32'hFFFFFFFB,  32'd0,         1'b1, 1'b0, 32'hFFFFFFFF, 1};
    vecs[12] = '{32'hFFFFFFFB,  32'd0,         1'b1, 1'b1, 32'hFFFFFFFB, 1};
    vecs[13] = '{32'd100,       32'hFFFFFFF9,  1'b1, 1'b0, 32'hFFFFFFF2, 34};
    vecs[14] = '{32'd100,       32'hFFFFFFF9,  1'b1, 1'b1, 32'h00000002, 34};
    vecs[15] = '{32'd1000,      32'd10,        1'b0, 1'b0, 32'h00000064, 34};
    vecs[16] = '{32'hFFFFFFFF,  32'h00000010,  1'b0, 1'b0, 32'h0FFFFFFF, 34};
    #2;
    compared++;
    if (result !== 32'h0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset: result=%h done=%b, expected 0/0", result, done);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) run(vecs[i], 0, 1'b0);
    run(vecs[15], 5, 1'b1);
    @(negedge clk);
    op_a = 32'd500; op_b = 32'd3; sgn = 1'b0; rem = 1'b0; div_en = 1'b1;
    repeat (11) @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (result !== 32'h0 || done !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_reset: result=%h done=%b, expected 0/0", result, done);
    end
    op_a = vecs[16].a; op_b = vecs[16].b; sgn = vecs[16].s; rem = vecs[16].r;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{vecs[16].e, vecs[16].lat, cyc + 1});
    wait_done();
    div_en = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
